// File: rtl/count_checker_pkg.sv
// Shared definitions for the count checker: FSM state encodings and default widths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package count_checker_pkg;

    // Default counter width shared with the counter under check and its benches.
    localparam int DEFAULT_WIDTH = 4;

    // Checker FSM encodings; kept as plain constants so older code can reuse them.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SYNC  = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

endpackage

// File: rtl/count_checker_model.sv
// Golden model of the loadable up-counter: expected count with load priority over enable.
// Latency: expected updates on every rising edge; wrap pulse is combinational for the coming edge.
// Backpressure: none, always accepts the snooped stimulus.
module count_model
    import count_checker_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_expected,
    output logic             o_wrap_pulse
);

    logic [WIDTH-1:0] r_expected;

    // Expected count register: load wins over enable, enable increments modulo 2**WIDTH.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_expected <= '0;
        end else if (i_load) begin
            r_expected <= i_d;
        end else if (i_en) begin
            r_expected <= r_expected + WIDTH'(1);
        end
    end

    // Only an increment out of all-ones is a rollover; loading zero is not.
    assign o_wrap_pulse = i_en & ~i_load & (r_expected == {WIDTH{1'b1}});
    assign o_expected   = r_expected;

endmodule

// File: rtl/count_checker.sv
// Passive monitor comparing a counter's q against a reference model; reports errors, captures, wraps.
// Latency: q seen before edge k+1 is compared at edge k+1; err is high in the cycle after that edge.
// Backpressure: none, snoops every cycle and never stalls the counter.
module count_checker
    import count_checker_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int ERR_CNT_W   = 8,
    parameter int WRAP_CNT_W  = 8,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_arm,
    input  logic                  i_load,
    input  logic                  i_en,
    input  logic [WIDTH-1:0]      i_d,
    input  logic [WIDTH-1:0]      i_q,
    output logic                  o_checking,
    output logic                  o_halted,
    output logic                  o_err,
    output logic [ERR_CNT_W-1:0]  o_err_count,
    output logic [WIDTH-1:0]      o_first_err_exp,
    output logic [WIDTH-1:0]      o_first_err_got,
    output logic [WRAP_CNT_W-1:0] o_wrap_count
);

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [WIDTH-1:0]      w_expected;
    logic                  w_wrap_pulse;
    logic                  w_in_check;
    logic                  w_hit;
    logic                  w_arm_entry;
    logic                  r_err;
    logic [ERR_CNT_W-1:0]  r_err_count;
    logic [WIDTH-1:0]      r_first_exp;
    logic [WIDTH-1:0]      r_first_got;
    logic                  r_first_seen;
    logic [WRAP_CNT_W-1:0] r_wrap_count;

    count_model #(
        .WIDTH (WIDTH)
    ) u_model (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_load       (i_load),
        .i_en         (i_en),
        .i_d          (i_d),
        .o_expected   (w_expected),
        .o_wrap_pulse (w_wrap_pulse)
    );

    assign w_in_check  = (r_state == ST_CHECK);
    assign w_hit       = w_in_check & (i_q != w_expected);
    assign w_arm_entry = (r_state == ST_IDLE) & i_arm;

    // Next-state logic: dropping arm always wins; SYNC waits for a load so the model is known.
    always_comb begin
        w_state_nxt = r_state;
        if (!i_arm) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  w_state_nxt = ST_SYNC;
                ST_SYNC:  if (i_load) w_state_nxt = ST_CHECK;
                ST_CHECK: if (w_hit && STOP_ON_ERR) w_state_nxt = ST_HALT;
                default:  w_state_nxt = ST_HALT;
            endcase
        end
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Error pulse: registered so it marks the cycle after the comparing edge, even if arm drops.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_hit;
        end
    end

    // Counts and first-mismatch capture: cleared on arming, frozen outside CHECK until the next arm.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_err_count  <= '0;
            r_first_exp  <= '0;
            r_first_got  <= '0;
            r_first_seen <= 1'b0;
            r_wrap_count <= '0;
        end else if (w_arm_entry) begin
            r_err_count  <= '0;
            r_first_exp  <= '0;
            r_first_got  <= '0;
            r_first_seen <= 1'b0;
            r_wrap_count <= '0;
        end else begin
            if (w_hit) begin
                if (r_err_count != {ERR_CNT_W{1'b1}}) begin
                    r_err_count <= r_err_count + ERR_CNT_W'(1);
                end
                if (!r_first_seen) begin
                    r_first_seen <= 1'b1;
                    r_first_exp  <= w_expected;
                    r_first_got  <= i_q;
                end
            end
            if (w_in_check && w_wrap_pulse) begin
                r_wrap_count <= r_wrap_count + WRAP_CNT_W'(1);
            end
        end
    end

    assign o_checking      = (r_state == ST_CHECK);
    assign o_halted        = (r_state == ST_HALT);
    assign o_err           = r_err;
    assign o_err_count     = r_err_count;
    assign o_first_err_exp = r_first_exp;
    assign o_first_err_got = r_first_got;
    assign o_wrap_count    = r_wrap_count;

endmodule

// File: tb/tb_count_checker.sv
// Bench for count_checker: three instances (default, 2-bit error count, stop-on-error) share stimulus.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_count_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       arm, load, en;
    logic [3:0] d, q;

    logic       chk_w  [3];
    logic       hlt_w  [3];
    logic       err_w  [3];
    logic [3:0] fexp_w [3];
    logic [3:0] fgot_w [3];
    logic [7:0] wrap_w [3];
    logic [7:0] ecnt_w [3];
    logic [7:0] ecnt0, ecnt2;
    logic [1:0] ecnt1;

    int errors = 0;
    int checks = 0;

    // Behavioural reference: mode 0 idle, 1 waiting for load, 2 checking, 3 halted.
    logic [3:0] m_exp;
    int         m_mode [3];
    int         m_cnt  [3];
    int         m_wrap [3];
    bit         m_err  [3];
    bit         m_first[3];
    logic [3:0] m_fexp [3];
    logic [3:0] m_fgot [3];
    int         m_max  [3] = '{255, 3, 255};
    bit         m_stop [3] = '{1'b0, 1'b0, 1'b1};

    always #5 clk = ~clk;

    always_comb begin
        ecnt_w[0] = ecnt0;
        ecnt_w[1] = {6'b0, ecnt1};
        ecnt_w[2] = ecnt2;
    end

    count_checker #(.WIDTH(4), .ERR_CNT_W(8), .WRAP_CNT_W(8), .STOP_ON_ERR(1'b0)) u_dut0 (
        .i_clk(clk), .i_reset(rst_n), .i_arm(arm), .i_load(load), .i_en(en), .i_d(d), .i_q(q),
        .o_checking(chk_w[0]), .o_halted(hlt_w[0]), .o_err(err_w[0]), .o_err_count(ecnt0),
        .o_first_err_exp(fexp_w[0]), .o_first_err_got(fgot_w[0]), .o_wrap_count(wrap_w[0]));

    count_checker #(.WIDTH(4), .ERR_CNT_W(2), .WRAP_CNT_W(8), .STOP_ON_ERR(1'b0)) u_dut1 (
        .i_clk(clk), .i_reset(rst_n), .i_arm(arm), .i_load(load), .i_en(en), .i_d(d), .i_q(q),
        .o_checking(chk_w[1]), .o_halted(hlt_w[1]), .o_err(err_w[1]), .o_err_count(ecnt1),
        .o_first_err_exp(fexp_w[1]), .o_first_err_got(fgot_w[1]), .o_wrap_count(wrap_w[1]));

    count_checker #(.WIDTH(4), .ERR_CNT_W(8), .WRAP_CNT_W(8), .STOP_ON_ERR(1'b1)) u_dut2 (
        .i_clk(clk), .i_reset(rst_n), .i_arm(arm), .i_load(load), .i_en(en), .i_d(d), .i_q(q),
        .o_checking(chk_w[2]), .o_halted(hlt_w[2]), .o_err(err_w[2]), .o_err_count(ecnt2),
        .o_first_err_exp(fexp_w[2]), .o_first_err_got(fgot_w[2]), .o_wrap_count(wrap_w[2]));

    task automatic model_reset();
        m_exp = 4'd0;
        for (int i = 0; i < 3; i++) begin
            m_mode[i] = 0; m_cnt[i] = 0; m_wrap[i] = 0; m_err[i] = 1'b0;
            m_first[i] = 1'b0; m_fexp[i] = 4'd0; m_fgot[i] = 4'd0;
        end
    endtask

    // Advance the reference by one clock using the currently driven inputs, then clock the DUTs.
    task automatic step();
        bit mis;
        bit in_chk;
        mis = (q != m_exp);
        for (int i = 0; i < 3; i++) begin
            in_chk   = (m_mode[i] == 2);
            m_err[i] = in_chk && mis;
            if (m_mode[i] == 0 && arm) begin
                m_cnt[i] = 0; m_wrap[i] = 0; m_first[i] = 1'b0; m_fexp[i] = 4'd0; m_fgot[i] = 4'd0;
            end
            if (in_chk && mis) begin
                if (m_cnt[i] < m_max[i]) m_cnt[i] = m_cnt[i] + 1;
                if (!m_first[i]) begin
                    m_first[i] = 1'b1; m_fexp[i] = m_exp; m_fgot[i] = q;
                end
            end
            if (in_chk && en && !load && m_exp == 4'd15) m_wrap[i] = (m_wrap[i] + 1) % 256;
            if (!arm)                m_mode[i] = 0;
            else if (m_mode[i] == 0) m_mode[i] = 1;
            else if (m_mode[i] == 1) m_mode[i] = load ? 2 : 1;
            else if (m_mode[i] == 2) m_mode[i] = (mis && m_stop[i]) ? 3 : 2;
        end
        if (load)    m_exp = d;
        else if (en) m_exp = m_exp + 4'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; arm = 1'b0; load = 1'b0; en = 1'b0; d = 4'd0; q = 4'd0;
        model_reset();
        #12;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({chk_w[i], hlt_w[i], err_w[i], ecnt_w[i], fexp_w[i], fgot_w[i], wrap_w[i]} !== 31'd0) begin
                errors++;
                $display("FAIL reset_outputs[%0d] got chk=%b hlt=%b err=%b cnt=%0d fexp=%h fgot=%h wrap=%0d, want all 0",
                         i, chk_w[i], hlt_w[i], err_w[i], ecnt_w[i], fexp_w[i], fgot_w[i], wrap_w[i]);
            end
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_count_wrap();
        arm = 1'b1; q = m_exp;
        step();
        load = 1'b1; d = 4'b1010; q = m_exp;
        step();
        load = 1'b0; en = 1'b1;
        for (int k = 0; k < 16; k++) begin
            q = m_exp;
            step();
            checks++;
            if (err_w[0] !== 1'b0) begin
                errors++;
                $display("FAIL wrap_no_err cycle %0d got err=%b want 0", k, err_w[0]);
            end
        end
        checks++;
        if (wrap_w[0] !== 8'd1 || wrap_w[0] !== 8'(m_wrap[0])) begin
            errors++;
            $display("FAIL wrap_count got %0d want 1 (model %0d)", wrap_w[0], m_wrap[0]);
        end
        checks++;
        if (chk_w[0] !== 1'b1) begin
            errors++;
            $display("FAIL wrap_checking got %b want 1", chk_w[0]);
        end
    endtask

    task automatic test_mismatch();
        en = 1'b0; load = 1'b1; d = 4'b0110; q = m_exp;
        step();
        load = 1'b0; q = 4'b0111;
        step();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (err_w[i] !== 1'b1) begin
                errors++;
                $display("FAIL mismatch_err[%0d] got %b want 1", i, err_w[i]);
            end
        end
        checks++;
        if (ecnt_w[0] !== 8'd1 || fexp_w[0] !== 4'b0110 || fgot_w[0] !== 4'b0111) begin
            errors++;
            $display("FAIL mismatch_capture got cnt=%0d exp=%b got=%b want 1/0110/0111",
                     ecnt_w[0], fexp_w[0], fgot_w[0]);
        end
        checks++;
        if (hlt_w[2] !== 1'b1 || hlt_w[0] !== 1'b0) begin
            errors++;
            $display("FAIL mismatch_halt got stop=%b nostop=%b want 1/0", hlt_w[2], hlt_w[0]);
        end
        q = m_exp;
        step();
        checks++;
        if (err_w[0] !== 1'b0 || ecnt_w[0] !== 8'd1) begin
            errors++;
            $display("FAIL mismatch_single_pulse got err=%b cnt=%0d want 0/1", err_w[0], ecnt_w[0]);
        end
    endtask

    task automatic test_load_priority();
        load = 1'b1; en = 1'b1; d = 4'b0011; q = m_exp;
        step();
        load = 1'b0; en = 1'b0; q = 4'b0011;
        step();
        step();
        checks++;
        if (err_w[0] !== 1'b0 || ecnt_w[0] !== 8'(m_cnt[0]) || m_exp !== 4'b0011) begin
            errors++;
            $display("FAIL load_priority got err=%b cnt=%0d want 0/%0d", err_w[0], ecnt_w[0], m_cnt[0]);
        end
    endtask

    task automatic test_saturate();
        arm = 1'b0; q = m_exp;
        step();
        arm = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ecnt_w[i] !== 8'd0 || wrap_w[i] !== 8'd0 || fexp_w[i] !== 4'd0 || fgot_w[i] !== 4'd0) begin
                errors++;
                $display("FAIL rearm_clear[%0d] got cnt=%0d wrap=%0d fexp=%h fgot=%h want 0",
                         i, ecnt_w[i], wrap_w[i], fexp_w[i], fgot_w[i]);
            end
        end
        load = 1'b1; d = 4'($urandom_range(0, 15)); q = m_exp;
        step();
        load = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            q = m_exp ^ 4'b0001;
            step();
            checks++;
            if (err_w[1] !== 1'b1 || ecnt_w[1] !== 8'((k < 3) ? k : 3) || ecnt_w[0] !== 8'(k)) begin
                errors++;
                $display("FAIL saturate mismatch %0d got err=%b cnt2b=%0d cnt8b=%0d want 1/%0d/%0d",
                         k, err_w[1], ecnt_w[1], ecnt_w[0], (k < 3) ? k : 3, k);
            end
        end
        q = m_exp;
        step();
        checks++;
        if (err_w[1] !== 1'b0 || ecnt_w[1] !== 8'd3) begin
            errors++;
            $display("FAIL saturate_hold got err=%b cnt=%0d want 0/3", err_w[1], ecnt_w[1]);
        end
    endtask

    task automatic test_halt();
        q = m_exp ^ 4'b1000;
        step();
        checks++;
        if (hlt_w[2] !== 1'b1 || err_w[2] !== 1'b0 || ecnt_w[2] !== 8'd1 || fgot_w[2] !== m_fgot[2]) begin
            errors++;
            $display("FAIL halt_ignores got hlt=%b err=%b cnt=%0d fgot=%h want 1/0/1/%h",
                     hlt_w[2], err_w[2], ecnt_w[2], fgot_w[2], m_fgot[2]);
        end
        arm = 1'b0; q = m_exp;
        step();
        checks++;
        if (hlt_w[2] !== 1'b0 || chk_w[0] !== 1'b0 || ecnt_w[2] !== 8'd1 ||
            fexp_w[2] !== m_fexp[2] || fgot_w[2] !== m_fgot[2]) begin
            errors++;
            $display("FAIL halt_disarm_hold got hlt=%b chk=%b cnt=%0d fexp=%h fgot=%h want 0/0/1/%h/%h",
                     hlt_w[2], chk_w[0], ecnt_w[2], fexp_w[2], fgot_w[2], m_fexp[2], m_fgot[2]);
        end
        arm = 1'b1;
        step();
        checks++;
        if (ecnt_w[2] !== 8'd0 || fexp_w[2] !== 4'd0 || fgot_w[2] !== 4'd0 || hlt_w[2] !== 1'b0) begin
            errors++;
            $display("FAIL halt_rearm_clear got cnt=%0d fexp=%h fgot=%h hlt=%b want 0/0/0/0",
                     ecnt_w[2], fexp_w[2], fgot_w[2], hlt_w[2]);
        end
    endtask

    task automatic test_reset_mid();
        load = 1'b1; d = 4'd5; q = m_exp;
        step();
        load = 1'b0; en = 1'b1;
        for (int k = 0; k < 2; k++) begin
            q = m_exp ^ 4'b0100;
            step();
        end
        checks++;
        if (ecnt_w[0] !== 8'd2 || err_w[0] !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_setup got cnt=%0d err=%b want 2/1", ecnt_w[0], err_w[0]);
        end
        rst_n = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({chk_w[i], hlt_w[i], err_w[i], ecnt_w[i], fexp_w[i], fgot_w[i], wrap_w[i]} !== 31'd0) begin
                errors++;
                $display("FAIL reset_mid[%0d] got chk=%b hlt=%b err=%b cnt=%0d fexp=%h fgot=%h wrap=%0d, want all 0",
                         i, chk_w[i], hlt_w[i], err_w[i], ecnt_w[i], fexp_w[i], fgot_w[i], wrap_w[i]);
            end
        end
        #2;
        rst_n = 1'b1; arm = 1'b0; en = 1'b0; q = 4'd9;
        step();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (err_w[i] !== 1'b0 || chk_w[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_after[%0d] got err=%b chk=%b want 0/0", i, err_w[i], chk_w[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] fault;
        for (int k = 0; k < 600; k++) begin
            arm   = ($urandom_range(0, 24) != 0);
            load  = ($urandom_range(0, 4) == 0);
            en    = ($urandom_range(0, 3) != 0);
            d     = 4'($urandom_range(0, 15));
            fault = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            q     = m_exp ^ fault;
            step();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (chk_w[i] !== (m_mode[i] == 2) || hlt_w[i] !== (m_mode[i] == 3) ||
                    err_w[i] !== m_err[i] || ecnt_w[i] !== 8'(m_cnt[i]) ||
                    fexp_w[i] !== m_fexp[i] || fgot_w[i] !== m_fgot[i] || wrap_w[i] !== 8'(m_wrap[i])) begin
                    errors++;
                    $display("FAIL random cyc %0d inst %0d got chk=%b hlt=%b err=%b cnt=%0d fexp=%h fgot=%h wrap=%0d want mode=%0d err=%b cnt=%0d fexp=%h fgot=%h wrap=%0d",
                             k, i, chk_w[i], hlt_w[i], err_w[i], ecnt_w[i], fexp_w[i], fgot_w[i], wrap_w[i],
                             m_mode[i], m_err[i], m_cnt[i], m_fexp[i], m_fgot[i], m_wrap[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_count_wrap();
        test_mismatch();
        test_load_priority();
        test_saturate();
        test_halt();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
